// File: rtl/rv_pkg.sv
// Shared core definitions: datapath widths and writeback requester indices.
package rv_pkg;

  localparam int RV_DATA_W = 32;
  localparam int RV_ADDR_W = 5;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_idx_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin arbiter for the register file write port,
// with a single registered output stage.
module rf_wr_arbiter
  import rv_pkg::*;
#(
  parameter int DATA_W = RV_DATA_W,
  parameter int ADDR_W = RV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  req_idx_e rr_ptr;
  logic     xfer0;
  logic     xfer1;
  logic     contend;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !hold) begin
      req0_ready = req0_valid & (!req1_valid | (rr_ptr == REQ_ALU));
      req1_ready = req1_valid & (!req0_valid | (rr_ptr == REQ_LOAD));
    end
  end

  assign xfer0   = req0_valid & req0_ready;
  assign xfer1   = req1_valid & req1_ready;
  assign contend = req0_valid & req1_valid;

  // NOTE: state uses non-blocking assignments, and every flop (including the
  // data register) is reset so a pre-reset write can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= REQ_ALU;
    end else begin
      rf_we <= 1'b0;
      if (xfer0) begin
        // Writes to x0 still transfer, but never enable the register file.
        rf_we    <= (req0_addr != '0);
        rf_waddr <= req0_addr;
        rf_wdata <= req0_data;
      end else if (xfer1) begin
        rf_we    <= (req1_addr != '0);
        rf_waddr <= req1_addr;
        rf_wdata <= req1_data;
      end
      if (contend && (xfer0 || xfer1))
        rr_ptr <= (rr_ptr == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    end
  end

  assign busy = rf_we;

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: write data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock. All state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port hold, input, 1 bit: while 1, no request is accepted.
REQ-006 SHALL have ports req0_valid (input, 1), req0_addr (input, ADDR_W), req0_data (input, DATA_W) and req0_ready (output, 1): requester 0, the ALU writeback path.
REQ-007 SHALL have ports req1_valid (input, 1), req1_addr (input, ADDR_W), req1_data (input, DATA_W) and req1_ready (output, 1): requester 1, the load/long-latency writeback path.
REQ-008 SHALL have port rf_we, output, 1 bit: register file write enable.
REQ-009 SHALL have port rf_waddr, output, ADDR_W bits: register file write address.
REQ-010 SHALL have port rf_wdata, output, DATA_W bits: register file write data.
REQ-011 SHALL have port busy, output, 1 bit: 1 when a write is presented on the rf_* ports in the current cycle.

Function
REQ-012 SHALL define a transfer on requester i as reqi_valid & reqi_ready at a rising clk edge.
REQ-013 SHALL derive reqi_ready combinationally from hold, both valids and the round-robin pointer rr_ptr.
- No register stage feeds reqi_ready.
REQ-014 SHALL drive req0_ready = !hold & req0_valid & (!req1_valid | rr_ptr==0).
REQ-015 SHALL drive req1_ready = !hold & req1_valid & (!req0_valid | rr_ptr==1).
REQ-016 SHALL grant at most one requester per cycle; the two readies are never both 1.
REQ-017 SHALL toggle rr_ptr to the other requester only when both valids are 1 and a transfer occurs; otherwise rr_ptr holds.
REQ-018 SHALL register each transfer with latency 1.
- A transfer at edge N sets rf_we, rf_waddr and rf_wdata for cycle N..N+1.
- The register file commits the write on the falling edge inside that cycle.
REQ-019 SHALL set rf_we = 0 for a transfer with addr == 0.
- The transfer still completes and still counts for rr_ptr.
- rf_waddr and rf_wdata still update.
REQ-020 SHALL drive rf_we = 0 in any cycle not preceded by a transfer; rf_waddr and rf_wdata hold their last values.
REQ-021 SHALL drive busy = rf_we.
REQ-022 SHALL apply no address-conflict check between requesters.
- Same-address requests are serialized in grant order.
- The later grant wins in the register file.
REQ-023 SHALL allow a requester to keep valid asserted with new data each cycle; back-to-back transfers give rf_we = 1 in consecutive cycles.
REQ-024 SHALL evaluate hold at the current edge only; releasing hold allows a grant on the same edge.
REQ-025 SHALL never drop a request: a requester that is not granted sees ready = 0 and keeps its valid.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously force rf_we = 0, rf_waddr = 0, rf_wdata = 0 and rr_ptr = 0.
REQ-027 SHALL hold req0_ready and req1_ready at 0 while rst_n = 0.
REQ-028 SHALL discard any write registered before reset is asserted mid-operation; it never appears on the rf_* ports.
REQ-029 SHALL accept requests on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL take DATA_W and ADDR_W defaults, and the requester index encoding (0 = ALU, 1 = load), from a shared package rv_pkg.
REQ-031 SHALL be one flat module with no sub-modules; the output register and rr_ptr flop are inline.

Verification
REQ-032 SHALL cover single requester: req0 valid, addr 5, data 0xDEADBEEF -> req0_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-033 SHALL cover contention: both valid for 4 cycles, rr_ptr=0 at start -> grants 0,1,0,1; rf_we high for 4 consecutive cycles.
REQ-034 SHALL cover x0 write: req1 addr 0, data 0x1234 -> req1_ready=1; next cycle rf_we=0; rr_ptr behaves per REQ-017.
REQ-035 SHALL cover hold: hold=1 with both valid for 3 cycles -> both readies 0 and rf_we=0; hold=0 -> grant on the same edge.
REQ-036 SHALL cover reset mid-operation: rst_n low while rf_we=1 -> rf_we=0, rf_waddr=0 and rf_wdata=0 immediately; rr_ptr=0 afterward.
REQ-037 SHALL cover same address: req0 addr 7 data 1 and req1 addr 7 data 2, both valid, rr_ptr=0 -> register 7 ends with value 2.
